// File: rtl/seq_rec_pkg.sv
// Shared constants and types for the streaming pattern recognizer.
// Holds the default parameter values, the character typedef and the
// wildcard code function used when SEQ_RECOGNIZER_WILDCARD_EN is defined.
package seq_rec_pkg;

  localparam int CHAR_W_DEF = 7;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 8;

  typedef logic [CHAR_W_DEF-1:0] char_t;

  // All-ones code of a char_w-bit character (7'h7F for 7-bit ASCII).
  function automatic logic [31:0] WILDCARD(input int char_w);
    if (char_w >= 32) begin
      return '1;
    end
    return (32'd1 << char_w) - 32'd1;
  endfunction

endpackage

// File: rtl/char_history.sv
// Character history: DEPTH-entry shift register plus a saturating fill
// counter telling how many entries are fresh (0..DEPTH).
// Entry 0 (bits [CHAR_W-1:0]) is the newest character.
// 'clear' only resets the fill count; history contents are kept, because a
// stale entry can never be matched while fill is below the pattern length.
// 'shift' and 'clear' may be high together: the character shifts in and the
// fill count still goes to 0.
module char_history #(
  parameter int CHAR_W = 7,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [CHAR_W-1:0]        in_char,
  output logic [DEPTH*CHAR_W-1:0]  hist,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  // Shift register: newest character enters at entry 0, oldest drops out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (shift) begin
      hist <= {hist[(DEPTH-1)*CHAR_W-1:0], in_char};
    end
  end

  // Fill counter: clear wins, otherwise count shifts up to DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (shift && (fill != FILL_MAX)) begin
      fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_recognizer.sv
// Streaming pattern recognizer top level.
// Accepts one character per in_valid cycle and pulses 'match' (registered,
// one cycle) when the newest pat_len characters equal the programmed
// pattern. Keeps a saturating match counter.
// Optional feature macro: SEQ_RECOGNIZER_WILDCARD_EN -- when defined, a
// pattern entry of all ones matches any character.
//
// Handshake: in_valid qualifies in_char for one cycle; there is no ready.
// Every in_valid cycle is accepted except one where pat_wr_en is high, in
// which case the character is dropped (no shift, no match).
module seq_recognizer
  import seq_rec_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [CHAR_W-1:0]        in_char,
  input  logic                     pat_wr_en,
  input  logic [$clog2(DEPTH)-1:0] pat_wr_idx,
  input  logic [CHAR_W-1:0]        pat_wr_char,
  input  logic [$clog2(DEPTH):0]   pat_len,
  input  logic                     overlap,
  input  logic                     cnt_clr,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SEQ_RECOGNIZER_WILDCARD_EN
  localparam logic [CHAR_W-1:0] WILD = CHAR_W'(WILDCARD(CHAR_W));
`endif

  // Pattern register file; entry 0 is the first (oldest) pattern character.
  logic [CHAR_W-1:0]       pattern [DEPTH];

  logic [DEPTH*CHAR_W-1:0] hist;
  logic [LEN_W-1:0]        fill;
  logic [LEN_W-1:0]        fill_plus;
  logic [CHAR_W-1:0]       cand [DEPTH];
  logic                    accept;
  logic                    len_ok;
  logic                    all_eq;
  logic                    hit;
  logic                    hist_clear;
  int                      pos;
  logic [IDX_W-1:0]        pidx;
  logic                    unused_oldest;

  // One pattern character against one history character.
  function automatic logic char_eq(input logic [CHAR_W-1:0] p,
                                   input logic [CHAR_W-1:0] c);
`ifdef SEQ_RECOGNIZER_WILDCARD_EN
    return (p == WILD) || (p == c);
`else
    return p == c;
`endif
  endfunction

  // A pattern write owns the cycle: any character offered with it is dropped.
  assign accept = in_valid && !pat_wr_en;

  // Non-overlap mode restarts fill after every match; a pattern write
  // always restarts it.
  assign hist_clear = pat_wr_en || (hit && !overlap);

  char_history #(
    .CHAR_W (CHAR_W),
    .DEPTH  (DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (accept),
    .clear   (hist_clear),
    .in_char (in_char),
    .hist    (hist),
    .fill    (fill)
  );

  // The incoming character takes candidate position 0, so the oldest stored
  // entry has already scrolled past the window when a match is evaluated.
  assign unused_oldest = ^hist[DEPTH*CHAR_W-1 -: CHAR_W];

  // Pattern register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        pattern[k] <= '0;
      end
    end else if (pat_wr_en) begin
      pattern[pat_wr_idx] <= pat_wr_char;
    end
  end

  // Candidate window as it looks after this edge's shift (newest first).
  always_comb begin
    cand[0] = in_char;
    for (int k = 1; k < DEPTH; k++) begin
      cand[k] = hist[(k-1)*CHAR_W +: CHAR_W];
    end
  end

  // Fill count including the character being accepted this edge.
  always_comb begin
    fill_plus = fill;
    if (fill != LEN_MAX) begin
      fill_plus = fill + 1'b1;
    end
  end

  // Per-position comparators masked by pat_len: pattern[i] must sit at
  // distance pat_len-1-i from the newest character.
  always_comb begin
    all_eq = 1'b1;
    pos    = 0;
    pidx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(pat_len)) begin
        pos = int'(pat_len) - 1 - i;
        if ((pos >= 0) && (pos < DEPTH)) begin
          pidx = pos[IDX_W-1:0];
          if (!char_eq(pattern[i], cand[pidx])) begin
            all_eq = 1'b0;
          end
        end
      end
    end
  end

  // Match decision for the character accepted this edge.
  assign len_ok = (pat_len != '0) && (pat_len <= LEN_MAX);
  assign hit    = accept && len_ok && (fill_plus >= pat_len) && all_eq;

  // Registered match pulse and saturating counter (clear with a match -> 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= hit;
      if (cnt_clr) begin
        match_count <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_recognizer.sv
// Self-checking bench for seq_recognizer. Two instances share stimulus: the
// default build and a CNT_W = 2 build for counter saturation. The reference
// model keeps the accepted-since-restart characters in a queue and compares
// the tail against the pattern directly.
module tb_seq_recognizer;
  import seq_rec_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 12;  // {match, match_count[7:0], match2, cnt2[1:0]}

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  char_t      in_char;
  logic       pat_wr_en;
  logic [2:0] pat_wr_idx;
  char_t      pat_wr_char;
  logic [3:0] pat_len;
  logic       overlap;
  logic       cnt_clr;
  logic       match;
  logic [7:0] match_count;
  logic       match2;
  logic [1:0] cnt2;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  char_t m_pat [DEPTH];
  char_t fresh[$];
  int    m_cnt;
  int    m_cnt2;

  // clock / reset
  always #5 clk = ~clk;

  seq_recognizer dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_char (in_char),
    .pat_wr_en (pat_wr_en), .pat_wr_idx (pat_wr_idx), .pat_wr_char (pat_wr_char),
    .pat_len (pat_len), .overlap (overlap), .cnt_clr (cnt_clr),
    .match (match), .match_count (match_count)
  );

  seq_recognizer #(.CNT_W(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_char (in_char),
    .pat_wr_en (pat_wr_en), .pat_wr_idx (pat_wr_idx), .pat_wr_char (pat_wr_char),
    .pat_len (pat_len), .overlap (overlap), .cnt_clr (cnt_clr),
    .match (match2), .match_count (cnt2)
  );

  function automatic logic pat_hit(input char_t p, input char_t c);
`ifdef SEQ_RECOGNIZER_WILDCARD_EN
    return (p == 7'h7F) || (p == c);
`else
    return p == c;
`endif
  endfunction

  // driver: one clock of stimulus, model update, sample of outputs
  task automatic cyc(input logic v, input char_t c, input logic we,
                     input logic [2:0] idx, input char_t wc, input logic clr);
    logic hit;
    int   n;
    int   pl;
    @(negedge clk);
    in_valid = v; in_char = c; pat_wr_en = we; pat_wr_idx = idx;
    pat_wr_char = wc; cnt_clr = clr;
    hit = 1'b0;
    pl  = int'(pat_len);
    if (we) begin
      m_pat[idx] = wc;
      fresh.delete();
    end else if (v) begin
      fresh.push_back(c);
      if (fresh.size() > DEPTH) fresh.delete(0);
      n = fresh.size();
      if (pl >= 1 && pl <= DEPTH && n >= pl) begin
        hit = 1'b1;
        for (int i = 0; i < pl; i++) begin
          if (!pat_hit(m_pat[i], fresh[n-pl+i])) hit = 1'b0;
        end
      end
      if (hit && !overlap) fresh.delete();
    end
    if (clr) begin
      m_cnt  = hit ? 1 : 0;
      m_cnt2 = hit ? 1 : 0;
    end else if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    exp_q.push_back({hit, 8'(m_cnt), hit, 2'(m_cnt2)});
    @(posedge clk);
    #1;
    act_q.push_back({match, match_count, match2, cnt2});
    in_valid = 1'b0; pat_wr_en = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, char_t'(s[i]), 1'b0, 3'd0, 7'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
  endtask

  task automatic clear_cnt();
    cyc(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b1);
  endtask

  task automatic program_pat(input string p);
    for (int i = 0; i < p.len(); i++) cyc(1'b0, 7'd0, 1'b1, 3'(i), char_t'(p[i]), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; pat_wr_en = 1'b0; cnt_clr = 1'b0;
    fresh.delete();
    for (int i = 0; i < DEPTH; i++) m_pat[i] = '0;
    m_cnt = 0; m_cnt2 = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e, a;
    int j = 0;
    do_reset();
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL reset_match: got %b, expected 0", match); end
    tests++; if (match_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d, expected 0", match_count); end
    tests++; if (match2 !== 1'b0) begin fails++; $display("FAIL reset_match2: got %b, expected 0", match2); end
    tests++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL reset_cnt2: got %0d, expected 0", cnt2); end
    // pattern resets to 0: a length-1 pattern matches character 0
    pat_len = 4'd1; overlap = 1'b1;
    cyc(1'b1, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    cyc(1'b1, 7'h41, 1'b0, 3'd0, 7'd0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL reset_pattern step %0d: got %h, expected %h", j, a, e); end
      j++;
    end
  endtask

  task automatic test_alexa();
    logic [W-1:0] e, a;
    int j = 0, pulses = 0, last = -1;
    program_pat("Alexa"); pat_len = 4'd5; overlap = 1'b0;
    clear_cnt();
    send_str("xAlexaz");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL alexa step %0d: got %h, expected %h", j, a, e); end
      if (a[W-1]) begin pulses++; last = j; end
      j++;
    end
    // 5 writes + 1 clear, then 'a' is the 6th streamed char -> step 11
    tests++; if (pulses != 1 || last != 11) begin fails++; $display("FAIL alexa_pulse: got %0d pulses at %0d, expected 1 at 11", pulses, last); end
    tests++; if (match_count !== 8'd1) begin fails++; $display("FAIL alexa_count: got %0d, expected 1", match_count); end
  endtask

  task automatic test_overlap();
    logic [W-1:0] e, a;
    int j, pulses, first, last;
    program_pat("aa"); pat_len = 4'd2; overlap = 1'b1;
    clear_cnt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL overlap_setup: got %h, expected %h", a, e); end
    end
    send_str("aaaa");
    j = 0; pulses = 0; first = -1; last = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL overlap step %0d: got %h, expected %h", j, a, e); end
      if (a[W-1]) begin pulses++; if (first < 0) first = j; last = j; end
      j++;
    end
    tests++; if (pulses != 3 || first != 1 || last != 3) begin fails++; $display("FAIL overlap_pulses: got %0d (%0d..%0d), expected 3 (1..3)", pulses, first, last); end
    overlap = 1'b0;
    program_pat("aa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL nonoverlap_setup: got %h, expected %h", a, e); end
    end
    send_str("aaaa");
    j = 0; pulses = 0; first = -1; last = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL nonoverlap step %0d: got %h, expected %h", j, a, e); end
      if (a[W-1]) begin pulses++; if (first < 0) first = j; last = j; end
      j++;
    end
    tests++; if (pulses != 2 || first != 1 || last != 3) begin fails++; $display("FAIL nonoverlap_pulses: got %0d (%0d..%0d), expected 2 (1,3)", pulses, first, last); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] e, a;
    int j = 0, pulses = 0;
    program_pat("Alexa"); pat_len = 4'd5; overlap = 1'b0;
    send_str("Al"); idle(3); send_str("exa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL gaps step %0d: got %h, expected %h", j, a, e); end
      if (a[W-1]) pulses++;
      j++;
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL gaps_pulses: got %0d, expected 1", pulses); end
  endtask

  task automatic test_write_drop();
    logic [W-1:0] e, a;
    int j = 0, pulses = 0;
    program_pat("Alexa"); pat_len = 4'd5; overlap = 1'b0;
    send_str("Alex");
    cyc(1'b1, 7'h61, 1'b1, 3'd0, 7'h41, 1'b0);  // 'a' offered with a write
    send_str("a");                               // fill restarted: no match
    send_str("Alexa");                           // one match
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL write_drop step %0d: got %h, expected %h", j, a, e); end
      if (a[W-1]) pulses++;
      j++;
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL write_drop_pulses: got %0d, expected 1", pulses); end
    for (int l = 0; l < 2; l++) begin
      pat_len = (l == 0) ? 4'd0 : 4'd9;
      pulses = 0;
      for (int k = 0; k < 24; k++) cyc(1'b1, char_t'($urandom_range(0, 1) ? 7'h61 : 7'h41), 1'b0, 3'd0, 7'd0, 1'b0);
      send_str("Alexa");
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
        if (a !== e) begin fails++; $display("FAIL bad_len %0d: got %h, expected %h", pat_len, a, e); end
        if (a[W-1]) pulses++;
      end
      tests++; if (pulses != 0) begin fails++; $display("FAIL bad_len_pulses len %0d: got %0d, expected 0", pat_len, pulses); end
    end
  endtask

  task automatic test_saturate();
    logic [W-1:0] e, a;
    int j = 0;
    program_pat("aa"); pat_len = 4'd2; overlap = 1'b1;
    clear_cnt();
    send_str("aaaaaa");  // 5 matches
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL saturate step %0d: got %h, expected %h", j, a, e); end
      j++;
    end
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2: got %0d, expected 3", cnt2); end
    tests++; if (match_count !== 8'd5) begin fails++; $display("FAIL sat_count: got %0d, expected 5", match_count); end
    cyc(1'b1, 7'h61, 1'b0, 3'd0, 7'd0, 1'b1);  // clear together with a match
    void'(exp_q.pop_front()); void'(act_q.pop_front());
    tests++; if (match_count !== 8'd1) begin fails++; $display("FAIL clr_with_match: got %0d, expected 1", match_count); end
    tests++; if (cnt2 !== 2'd1) begin fails++; $display("FAIL clr_with_match2: got %0d, expected 1", cnt2); end
    cyc(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b1);   // clear alone
    void'(exp_q.pop_front()); void'(act_q.pop_front());
    tests++; if (match_count !== 8'd0) begin fails++; $display("FAIL clr_alone: got %0d, expected 0", match_count); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e, a;
    int pulses = 0;
    program_pat("Alexa"); pat_len = 4'd5; overlap = 1'b0;
    send_str("Ale");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL reset_mid_pre: got %h, expected %h", a, e); end
    end
    do_reset();
    tests++; if (match_count !== 8'd0) begin fails++; $display("FAIL reset_mid_count: got %0d, expected 0", match_count); end
    program_pat("Alexa");
    send_str("xa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL reset_mid_post: got %h, expected %h", a, e); end
      if (a[W-1]) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL reset_mid_pulses: got %0d, expected 0", pulses); end
  endtask

  task automatic test_wildcard();
    logic [W-1:0] e, a;
    int pulses = 0, want;
    string p;
    p = "A?exa";
    p[1] = 8'h7F;
    program_pat(p); pat_len = 4'd5; overlap = 1'b0;
    send_str("Alexa"); send_str("Abexa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL wildcard: got %h, expected %h", a, e); end
      if (a[W-1]) pulses++;
    end
`ifdef SEQ_RECOGNIZER_WILDCARD_EN
    want = 2;
`else
    want = 0;
`endif
    tests++; if (pulses != want) begin fails++; $display("FAIL wildcard_pulses: got %0d, expected %0d", pulses, want); end
  endtask

  task automatic test_random();
    logic [W-1:0] e, a;
    int j = 0, r;
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 7'd0, 1'b1, 3'(i), $urandom_range(0, 1) ? 7'h61 : 7'h62, 1'b0);
    pat_len = 4'($urandom_range(1, 4)); overlap = 1'($urandom_range(0, 1));
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cyc(1'($urandom_range(0, 1)), 7'h61, 1'b1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) ? 7'h61 : 7'h62, 1'b0);
      end else begin
        if (r < 6) pat_len = 4'($urandom_range(0, 9));
        else if (r < 9) overlap = ~overlap;
        cyc(($urandom_range(0, 99) < 75), $urandom_range(0, 1) ? 7'h61 : 7'h62, 1'b0, 3'd0, 7'd0, ($urandom_range(0, 99) < 2));
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin fails++; $display("FAIL random step %0d: got %h, expected %h", j, a, e); end
      j++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_char = '0; pat_wr_en = 1'b0;
    pat_wr_idx = '0; pat_wr_char = '0; pat_len = 4'd0; overlap = 1'b0; cnt_clr = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
    test_reset();
    test_alexa();
    test_overlap();
    test_gaps();
    test_write_drop();
    test_saturate();
    test_reset_mid();
    test_wildcard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
